// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Framed byte-stream boot loader that fills instruction memory,
//               verifies an XOR checksum, and then releases the core from halt.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              hlt,
    output logic              preset,
    output logic [31:0]       start_addr,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [2:0]  c_s_idle = 3'd0;
    localparam logic [2:0]  c_s_hdr  = 3'd1;
    localparam logic [2:0]  c_s_data = 3'd2;
    localparam logic [2:0]  c_s_csum = 3'd3;
    localparam logic [2:0]  c_s_boot = 3'd4;
    localparam logic [2:0]  c_s_run  = 3'd5;
    localparam logic [2:0]  c_s_err  = 3'd6;

    localparam logic [16:0] c_depth  = 17'd1 << ADDR_W;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [2:0]        r_byte_cnt;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_word_idx;
    logic [7:0]        r_csum;
    logic [31:0]       r_asm;
    logic [31:0]       r_start_addr;
    logic              w_accept;
    logic              w_is_sync;
    logic              w_last_word;

    assign w_accept    = rx_valid & rx_ready;
    assign w_is_sync   = (rx_data == SYNC);
    assign w_last_word = ({{(16-ADDR_W){1'b0}}, r_word_idx} == (r_cnt - 16'd1));
    assign start_addr  = r_start_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_s_idle, c_s_err: begin
                if (w_accept && w_is_sync) w_next_state = c_s_hdr;
            end
            c_s_hdr: begin
                if (w_accept && r_byte_cnt == 3'd5) begin
                    if ({1'b0, r_cnt} > c_depth) w_next_state = c_s_err;
                    else if (r_cnt == 16'd0)     w_next_state = c_s_csum;
                    else                         w_next_state = c_s_data;
                end
            end
            c_s_data: begin
                if (w_accept && r_byte_cnt == 3'd3 && w_last_word) w_next_state = c_s_csum;
            end
            c_s_csum: begin
                if (w_accept) w_next_state = (rx_data == r_csum) ? c_s_boot : c_s_err;
            end
            c_s_boot: w_next_state = c_s_run;
            c_s_run:  w_next_state = c_s_run;
            default:  w_next_state = c_s_idle;
        endcase
    end

    always_comb begin
        hlt       = 1'b1;
        preset    = 1'b0;
        rx_ready  = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            c_s_idle, c_s_hdr, c_s_data, c_s_csum: rx_ready = 1'b1;
            c_s_boot: begin
                hlt    = 1'b0;
                preset = 1'b1;
            end
            c_s_run: begin
                hlt       = 1'b0;
                load_done = 1'b1;
            end
            c_s_err: begin
                rx_ready = 1'b1;
                load_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Header fields, byte assembly and the one-cycle write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt   <= 3'd0;
            r_cnt        <= 16'd0;
            r_word_idx   <= '0;
            r_csum       <= 8'd0;
            r_asm        <= 32'd0;
            r_start_addr <= 32'd0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                c_s_idle, c_s_err: begin
                    if (w_accept && w_is_sync) begin
                        r_byte_cnt <= 3'd0;
                        r_cnt      <= 16'd0;
                        r_word_idx <= '0;
                        r_csum     <= 8'd0;
                        r_asm      <= 32'd0;
                    end
                end
                c_s_hdr: begin
                    if (w_accept) begin
                        r_byte_cnt <= (r_byte_cnt == 3'd5) ? 3'd0 : r_byte_cnt + 3'd1;
                        case (r_byte_cnt)
                            3'd0:    r_cnt[7:0]   <= rx_data;
                            3'd1:    r_cnt[15:8]  <= rx_data;
                            default: r_start_addr <= {rx_data, r_start_addr[31:8]};
                        endcase
                    end
                end
                c_s_data: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ rx_data;
                        r_asm  <= {rx_data, r_asm[31:8]};
                        if (r_byte_cnt == 3'd3) begin
                            r_byte_cnt <= 3'd0;
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_data, r_asm[31:8]};
                            imem_waddr <= r_word_idx;
                            r_word_idx <= r_word_idx + 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              hlt;
    logic              preset;
    logic [31:0]       start_addr;
    logic              load_done;
    logic              load_err;

    imem_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .hlt        (hlt),
        .preset     (preset),
        .start_addr (start_addr),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] pa_q[$];
    logic [7:0]  fr[$];
    logic [31:0] words[8];

    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(32'(imem_waddr));
            wd_q.push_back(imem_wdata);
        end
        if (preset) pa_q.push_back(start_addr);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        pa_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Frame with the checksum derived from the data bytes; flip corrupts it.
    task automatic build_frame(input int cnt, input logic [31:0] addr, input logic [7:0] flip);
        logic [7:0] x;
        logic [7:0] b;
        fr.delete();
        x = 8'd0;
        fr.push_back(8'hA5);
        fr.push_back(cnt[7:0]);
        fr.push_back(cnt[15:8]);
        for (int i = 0; i < 4; i++) fr.push_back(addr[8*i +: 8]);
        for (int w = 0; w < cnt; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                x = x ^ b;
                fr.push_back(b);
            end
        end
        fr.push_back(x ^ flip);
    endtask

    task automatic send_frame(input int gmax);
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], (gmax == 0) ? 0 : (i % (gmax + 1)));
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, (i < wa_q.size()) ? wa_q[i] : 32'hDEADBEEF, 32'(i));
            check({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 32'hDEADBEEF, words[i]);
        end
    endtask

    task automatic check_boot(input string tag, input logic [31:0] addr);
        check({tag, "_npreset"}, 32'(pa_q.size()), 32'd1);
        check({tag, "_start"}, (pa_q.size() > 0) ? pa_q[0] : 32'hDEADBEEF, addr);
        check({tag, "_hlt"}, 32'(hlt), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_err"}, 32'(load_err), 32'd0);
        check({tag, "_ready"}, 32'(rx_ready), 32'd0);
    endtask

    initial begin
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        for (int i = 2; i < 8; i++) words[i] = 32'h0;

        // Reset state
        do_reset();
        check("rst_hlt", 32'(hlt), 32'd1);
        check("rst_preset", 32'(preset), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_start", start_addr, 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd1);

        // Basic two-word load
        build_frame(2, 32'h0, 8'h00);
        send_frame(0);
        repeat (3) @(negedge clk);
        check_writes("t1", 2);
        check_boot("t1", 32'h0);

        // RUN ignores further input
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check("run_ignore_done", 32'(load_done), 32'd1);
        check("run_ignore_nwr", 32'(wa_q.size()), 32'd2);
        check("run_ignore_npreset", 32'(pa_q.size()), 32'd1);

        // Bad checksum, then recovery from ERR
        do_reset();
        build_frame(2, 32'h0, 8'h01);
        send_frame(0);
        repeat (2) @(negedge clk);
        check("t2_err", 32'(load_err), 32'd1);
        check("t2_hlt", 32'(hlt), 32'd1);
        check("t2_npreset", 32'(pa_q.size()), 32'd0);
        check("t2_done", 32'(load_done), 32'd0);
        check("t2_ready", 32'(rx_ready), 32'd1);
        clear_q();
        build_frame(2, 32'h0, 8'h00);
        send_frame(0);
        repeat (3) @(negedge clk);
        check_writes("t2r", 2);
        check_boot("t2r", 32'h0);

        // Empty image, boot address from header
        do_reset();
        build_frame(0, 32'h0000_0040, 8'h00);
        send_frame(0);
        repeat (3) @(negedge clk);
        check("t3_nwr", 32'(wa_q.size()), 32'd0);
        check_boot("t3", 32'h0000_0040);

        // Count beyond capacity
        do_reset();
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'((DEPTH + 1) & 255));
        fr.push_back(8'((DEPTH + 1) >> 8));
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
        send_frame(0);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_hlt", 32'(hlt), 32'd1);
        repeat (2) @(negedge clk);
        check("t4_nwr", 32'(wa_q.size()), 32'd0);
        check("t4_npreset", 32'(pa_q.size()), 32'd0);

        // Leading garbage and input gaps
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 2);
        check("t5_garbage_err", 32'(load_err), 32'd0);
        build_frame(2, 32'h0, 8'h00);
        send_frame(5);
        repeat (3) @(negedge clk);
        check_writes("t5", 2);
        check_boot("t5", 32'h0);

        // Reset in the middle of a four-word frame
        do_reset();
        words[0] = 32'h1122_3344;
        words[1] = 32'hA5A5_0F0F;
        words[2] = 32'hDEAD_BEEF;
        words[3] = 32'h0000_0001;
        build_frame(4, 32'h0000_1000, 8'h00);
        for (int i = 0; i < 15; i++) send_byte(fr[i], 0);
        check("t6_we_before_rst", 32'(imem_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_hlt", 32'(hlt), 32'd1);
        check("t6_we", 32'(imem_we), 32'd0);
        check("t6_waddr", 32'(imem_waddr), 32'd0);
        check("t6_wdata", imem_wdata, 32'd0);
        check("t6_ready", 32'(rx_ready), 32'd1);
        check("t6_done", 32'(load_done), 32'd0);
        rst = 1'b0;
        check_writes("t6", 2);
        clear_q();
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        build_frame(2, 32'h0, 8'h00);
        send_frame(0);
        repeat (3) @(negedge clk);
        check_writes("t6r", 2);
        check_boot("t6r", 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
